// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg -- shared definitions for the dmem_sram data memory.
//   DMEM_DEPTH / DMEM_AW / DMEM_DW : default geometry (128 x 32-bit words)
//   state_e                        : init-sweep FSM states {INIT, READY}
// ---------------------------------------------------------------------------
package dmem_pkg;

  localparam int DMEM_DEPTH = 128;
  localparam int DMEM_AW    = 7;
  localparam int DMEM_DW    = 32;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/dmem_init_seq.sv
// ---------------------------------------------------------------------------
// dmem_init_seq -- zero-fill sweep sequencer for dmem_sram.
// After reset it walks every word address once (one word per cycle), then
// parks in READY until the next reset.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous reset, ACTIVE-HIGH despite the name
//   busy      : high while the sweep runs (state INIT)
//   init_we   : write enable for the sweep's zero write
//   init_addr : word address being cleared this cycle
// ---------------------------------------------------------------------------
module dmem_init_seq
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = DMEM_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          busy,
  output logic          init_we,
  output logic [AW-1:0] init_addr
);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_d = READY;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == INIT);
  assign init_we   = (state_q == INIT);
  assign init_addr = cnt_q;

endmodule

// File: rtl/dmem_sram.sv
// ---------------------------------------------------------------------------
// dmem_sram -- single-port synchronous data SRAM with power-on zero sweep.
// Optional feature: define DMEM_PARITY_EN to store an even-parity bit per word
// and flag mismatches on read.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : synchronous reset, ACTIVE-HIGH despite the name
//   CEN     : chip enable, active-low
//   WEN     : 0 = write, 1 = read (only while CEN = 0)
//   OEN     : output enable, active-low, purely combinational on Q
//   A       : word address
//   D       : write data
//   Q       : read data (registered, 1-cycle latency; zero while OEN = 1)
//   busy    : high while the zero sweep runs; requests are ignored then
//   inj_par : test hook, inverts the stored parity bit on a write
//   par_err : parity mismatch seen on the last read (0 without parity)
// ---------------------------------------------------------------------------
module dmem_sram
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = DMEM_AW,
  parameter int DW    = DMEM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          CEN,
  input  logic          WEN,
  input  logic          OEN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] D,
  output logic [DW-1:0] Q,
  output logic          busy,
  input  logic          inj_par,
  output logic          par_err
);

  logic          init_we;
  logic [AW-1:0] init_addr;

  dmem_init_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .busy      (busy),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  // NOTE: the storage array has no reset; the sweep clears it, keeping it mappable to SRAM.
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_q, rd_d;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;

  // The sweep owns the write port while busy; core requests are dropped.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = A;
    wr_data = D;
    if (busy) begin
      wr_en   = init_we;
      wr_addr = init_addr;
      wr_data = '0;
    end else if (!CEN && !WEN) begin
      wr_en = 1'b1;
    end
  end

  assign rd_en = !busy && !CEN && WEN;

  always_comb begin
    rd_d = rd_q;
    if (busy) begin
      rd_d = '0;
    end else if (rd_en) begin
      rd_d = mem_q[A];
    end
  end

  // A write coinciding with a reset edge is discarded.
  always_ff @(posedge clk) begin
    if (wr_en && !rst_n) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign Q = OEN ? '0 : rd_q;

`ifdef DMEM_PARITY_EN
  logic par_mem_q [DEPTH];
  logic wr_par;
  logic par_err_q, par_err_d;

  // Even parity: stored bit makes the word plus parity have an even count of ones.
  always_comb begin
    wr_par    = busy ? 1'b0 : ((^D) ^ inj_par);
    par_err_d = par_err_q;
    if (busy) begin
      par_err_d = 1'b0;
    end else if (rd_en) begin
      par_err_d = (^mem_q[A]) != par_mem_q[A];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst_n) begin
      par_mem_q[wr_addr] <= wr_par;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  logic unused_inj_par;
  assign unused_inj_par = inj_par;
  assign par_err        = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_sram.sv
// ---------------------------------------------------------------------------
// tb_dmem_sram -- scoreboard bench for dmem_sram.
// Stimulus tasks push the expected Q / par_err into exp_q and raise
// sample_req; the monitor pops and compares on the following falling edge.
// Define DMEM_PARITY_EN for both DUT and bench to exercise parity.
// ---------------------------------------------------------------------------
module tb_dmem_sram;

`ifdef DMEM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        CEN, WEN, OEN, inj_par;
  logic [6:0]  A;
  logic [31:0] D;
  logic [31:0] Q;
  logic        busy, par_err;

  dmem_sram dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .CEN     (CEN),
    .WEN     (WEN),
    .OEN     (OEN),
    .A       (A),
    .D       (D),
    .Q       (Q),
    .busy    (busy),
    .inj_par (inj_par),
    .par_err (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] q;
    logic        par;
  } exp_t;

  exp_t exp_q[$];
  logic sample_req;
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (sample_req) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL monitor: output sampled with empty scoreboard, Q=0x%08h", Q);
      end else begin
        e = exp_q.pop_front();
        check({e.name, " Q"}, Q, e.q);
        check({e.name, " par_err"}, {31'b0, par_err}, {31'b0, e.par});
      end
    end
  end

  // All tasks start and end at posedge + 1.
  task automatic do_write(input logic [6:0] addr, input logic [31:0] data, input logic inj);
    CEN = 1'b0; WEN = 1'b0; A = addr; D = data; inj_par = inj;
    @(posedge clk); #1;
    CEN = 1'b1; WEN = 1'b1; inj_par = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [6:0] addr, input logic [31:0] exp_v,
                         input logic exp_par, input logic oen);
    CEN = 1'b0; WEN = 1'b1; A = addr; OEN = oen;
    @(posedge clk); #1;
    CEN = 1'b1;
    A   = addr ^ 7'h55;  // a combinational read path would now show another word
    exp_q.push_back('{name: name, q: (oen ? 32'h0 : exp_v), par: exp_par});
    sample_req = 1'b1;
    @(posedge clk); #1;
    sample_req = 1'b0;
  endtask

  task automatic peek(input string name, input logic oen, input logic [31:0] exp_v, input logic exp_par);
    OEN = oen;
    exp_q.push_back('{name: name, q: exp_v, par: exp_par});
    sample_req = 1'b1;
    @(posedge clk); #1;
    sample_req = 1'b0;
  endtask

  // Counts falling edges with busy high; stops at 1000 so a stuck sweep still ends.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == 64) begin
        check("Q during INIT", Q, 32'h0);
        check("par_err during INIT", {31'b0, par_err}, 32'h0);
      end
    end
  endtask

  int n;

  initial begin
    rst_n = 1'b1; CEN = 1'b1; WEN = 1'b1; OEN = 1'b0; inj_par = 1'b0;
    A = '0; D = '0; sample_req = 1'b0;

    // Two reset edges, then release.
    @(posedge clk); #1;
    @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'h1);
    check("reset Q", Q, 32'h0);
    check("reset par_err", {31'b0, par_err}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;

    // Requests during the sweep must be ignored.
    CEN = 1'b0; WEN = 1'b0; A = 7'h05; D = 32'hFFFF_FFFF; inj_par = 1'b1;
    count_busy(n);
    CEN = 1'b1; WEN = 1'b1; inj_par = 1'b0;
    check("busy cycles after reset", n, 128);
    @(posedge clk); #1;

    do_read("init A=0",   7'd0,   32'h0, 1'b0, 1'b0);
    do_read("init A=64",  7'd64,  32'h0, 1'b0, 1'b0);
    do_read("init A=127", 7'd127, 32'h0, 1'b0, 1'b0);
    do_read("init A=5 ignored write", 7'd5, 32'h0, 1'b0, 1'b0);

    // Read-after-write and OEN gating.
    do_write(7'h05, 32'hDEAD_BEEF, 1'b0);
    do_read("raw A=5", 7'h05, 32'hDEAD_BEEF, 1'b0, 1'b0);
    peek("A=5 OEN=1", 1'b1, 32'h0, 1'b0);
    peek("A=5 OEN=0 again", 1'b0, 32'hDEAD_BEEF, 1'b0);

    // A write and an idle cycle leave the read register alone.
    do_write(7'd3, 32'h1, 1'b0);
    peek("hold after write", 1'b0, 32'hDEAD_BEEF, 1'b0);
    peek("hold after idle", 1'b0, 32'hDEAD_BEEF, 1'b0);
    do_read("read A=3", 7'd3, 32'h1, 1'b0, 1'b0);

    // Address boundaries.
    do_write(7'd127, 32'hA5A5_5A5A, 1'b0);
    do_write(7'd0, 32'h1234_5678, 1'b0);
    do_read("read A=127", 7'd127, 32'hA5A5_5A5A, 1'b0, 1'b0);
    do_read("read A=0", 7'd0, 32'h1234_5678, 1'b0, 1'b0);
    do_read("read A=5 kept", 7'h05, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Parity injection (par_err stays 0 without the feature).
    do_write(7'd9, 32'h3, 1'b1);
    do_read("par inj A=9", 7'd9, 32'h3, PAR_ON, 1'b0);
    peek("par_err held", 1'b0, 32'h3, PAR_ON);
    do_write(7'd9, 32'h3, 1'b0);
    do_read("par clean A=9", 7'd9, 32'h3, 1'b0, 1'b0);
    do_write(7'd10, 32'h7, 1'b0);
    do_read("par odd word A=10", 7'd10, 32'h7, 1'b0, 1'b0);

    // Reset, then reset again at sweep cycle 50.
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("Q cleared by reset", Q, 32'h0);
    @(posedge clk); #1;
    repeat (49) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    CEN = 1'b0; WEN = 1'b0; A = 7'd20; D = 32'hCAFE_F00D;
    @(posedge clk); #1;
    rst_n = 1'b0;
    count_busy(n);
    CEN = 1'b1; WEN = 1'b1;
    check("busy cycles after mid-sweep reset", n, 128);
    @(posedge clk); #1;
    do_read("after re-sweep A=5", 7'h05, 32'h0, 1'b0, 1'b0);
    do_read("after re-sweep A=127", 7'd127, 32'h0, 1'b0, 1'b0);
    do_read("after re-sweep A=20", 7'd20, 32'h0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
